// File: rtl/axis_frame_player_pkg.sv
// rtl/axis_frame_player_pkg.sv - shared types and helpers for the frame player
package axis_frame_player_pkg;

    localparam int CX_WIDTH = 16;

    typedef struct packed {
        logic signed [CX_WIDTH-1:0] im;
        logic signed [CX_WIDTH-1:0] re;
    } cx_t;

    typedef enum logic [1:0] {
        IDLE,
        PLAY,
        DRAIN
    } player_state_t;

    function automatic int addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/axis_skid.sv
// rtl/axis_skid.sv - 2-entry AXI-Stream skid buffer carrying tdata, tlast and tuser
module axis_skid #(
    parameter int DATA_W = 32,
    parameter int USER_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    input  logic              s_axis_tlast,
    input  logic [USER_W-1:0] s_axis_tuser,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              m_axis_tlast,
    output logic [USER_W-1:0] m_axis_tuser,
    output logic [1:0]        count
);

    localparam int EW = DATA_W + 1 + USER_W;

    logic [EW-1:0] ent_q [2];
    logic          wr_ptr_q;
    logic          rd_ptr_q;
    logic [1:0]    count_q;
    logic          push;
    logic          pop;

    assign s_axis_tready = (count_q != 2'd2);
    assign m_axis_tvalid = (count_q != 2'd0);
    assign push          = s_axis_tvalid && s_axis_tready;
    assign pop           = m_axis_tvalid && m_axis_tready;
    assign count         = count_q;

    // Head entry drives the outputs directly, so it holds steady while stalled.
    assign {m_axis_tdata, m_axis_tlast, m_axis_tuser} = ent_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            ent_q[0] <= '0;
            ent_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push) begin
                ent_q[wr_ptr_q] <= {s_axis_tdata, s_axis_tlast, s_axis_tuser};
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule

// File: rtl/axis_frame_player.sv
// rtl/axis_frame_player.sv - replays a loaded sample buffer as framed AXI-Stream traffic
module axis_frame_player
    import axis_frame_player_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int DEPTH     = 64,
    parameter int FRAME_LEN = DEPTH,
    parameter int CNT_WID   = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        wr_en,
    input  logic [addr_w(DEPTH)-1:0]    wr_addr,
    input  logic [2*WIDTH-1:0]          wr_data,
    input  logic                        start,
    input  logic                        stop,
    input  logic                        loop,
    input  logic [CNT_WID-1:0]          nframes,
    output logic [2*WIDTH-1:0]          m_axis_tdata,
    output logic                        m_axis_tvalid,
    input  logic                        m_axis_tready,
    output logic                        m_axis_tlast,
    output logic [CNT_WID-1:0]          m_axis_tuser,
    output logic                        busy,
    output logic                        done,
    output logic                        wr_err
);

    localparam int AW = addr_w(DEPTH);
    localparam int DW = 2 * WIDTH;

    if ((DEPTH % FRAME_LEN) != 0) begin : g_frame_len_check
        $error("axis_frame_player: DEPTH must be a multiple of FRAME_LEN");
    end

    player_state_t      state_q, state_d;
    logic [DW-1:0]      mem [DEPTH];
    logic [AW-1:0]      rd_addr_q;
    logic [CNT_WID-1:0] iss_frame_q;
    logic [CNT_WID-1:0] frames_left_q;
    logic               rd_valid_q;
    logic               rd_last_q;
    logic [DW-1:0]      rd_data_q;
    logic [CNT_WID-1:0] rd_user_q;
    logic               loop_q;
    logic               stop_q;
    logic               done_q;
    logic               wr_err_q;

    logic               skid_in_valid;
    logic               skid_in_ready;
    logic               skid_tvalid;
    logic               skid_tready;
    logic [1:0]         skid_count;

    logic               zero_start;
    logic               wr_ok;
    logic               rd_last;
    logic               pop;
    logic               last_hs;
    logic               end_play;
    logic               issue;
    logic               done_d;
    logic [2:0]         occ_after;

    assign zero_start = !loop && (nframes == '0);
    assign wr_ok      = wr_en && (state_q == IDLE);
    assign rd_last    = ((int'(rd_addr_q) % FRAME_LEN) == (FRAME_LEN - 1));

    assign m_axis_tvalid = skid_tvalid && (state_q == PLAY);
    assign skid_tready   = m_axis_tready && (state_q == PLAY);
    assign pop           = m_axis_tvalid && m_axis_tready;
    assign last_hs       = pop && m_axis_tlast;
    assign end_play      = last_hs && (stop_q || stop || (!loop_q && (frames_left_q == CNT_WID'(1))));

    // Occupancy the skid will have once the in-flight read lands; a new read is safe while <= 1.
    assign occ_after = {1'b0, skid_count} + {2'b00, rd_valid_q} - {2'b00, pop};

    assign skid_in_valid = rd_valid_q && (state_q == PLAY) && skid_in_ready;

    assign busy   = (state_q != IDLE);
    assign done   = done_q;
    assign wr_err = wr_err_q;

    always_comb begin
        state_d = state_q;
        issue   = 1'b0;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (zero_start) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = PLAY;
                        issue   = 1'b1;
                    end
                end
            end
            PLAY: begin
                issue = (occ_after <= 3'd1);
                if (end_play) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // A write colliding with the start-cycle read is forwarded so it is seen by playback.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_addr] <= wr_data;
        end
        if (issue) begin
            rd_data_q <= (wr_ok && (wr_addr == rd_addr_q)) ? wr_data : mem[rd_addr_q];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            rd_addr_q     <= '0;
            iss_frame_q   <= '0;
            rd_valid_q    <= 1'b0;
            rd_last_q     <= 1'b0;
            rd_user_q     <= '0;
            loop_q        <= 1'b0;
            frames_left_q <= '0;
            stop_q        <= 1'b0;
            done_q        <= 1'b0;
            wr_err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            done_q     <= done_d;
            wr_err_q   <= wr_en && (state_q != IDLE);
            rd_valid_q <= issue;
            if (issue) begin
                rd_last_q <= rd_last;
                rd_user_q <= iss_frame_q;
            end
            if (state_q == DRAIN) begin
                rd_addr_q   <= '0;
                iss_frame_q <= '0;
            end else if (issue) begin
                rd_addr_q <= rd_addr_q + 1'b1;
                if (rd_last) begin
                    iss_frame_q <= iss_frame_q + 1'b1;
                end
            end
            if (state_q == IDLE) begin
                stop_q <= start && stop && !zero_start;
                if (start) begin
                    loop_q        <= loop;
                    frames_left_q <= nframes;
                end
            end else if (state_q == DRAIN) begin
                stop_q <= 1'b0;
            end else begin
                if (stop) begin
                    stop_q <= 1'b1;
                end
                if (last_hs) begin
                    frames_left_q <= frames_left_q - 1'b1;
                end
            end
        end
    end

    // Entries prefetched past the final frame are discarded during DRAIN.
    axis_skid #(
        .DATA_W (DW),
        .USER_W (CNT_WID)
    ) u_skid (
        .clk           (clk),
        .rst           (rst),
        .flush         (state_q == DRAIN),
        .s_axis_tdata  (rd_data_q),
        .s_axis_tvalid (skid_in_valid),
        .s_axis_tready (skid_in_ready),
        .s_axis_tlast  (rd_last_q),
        .s_axis_tuser  (rd_user_q),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (skid_tvalid),
        .m_axis_tready (skid_tready),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tuser  (m_axis_tuser),
        .count         (skid_count)
    );

endmodule

// File: tb/tb_axis_frame_player.sv
// tb/tb_axis_frame_player.sv - self-checking bench for axis_frame_player
module tb_axis_frame_player;
    import axis_frame_player_pkg::*;

    localparam int WIDTH     = 16;
    localparam int DEPTH     = 64;
    localparam int FRAME_LEN = 16;
    localparam int CNT_WID   = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         wr_en = 1'b0;
    logic [5:0]   wr_addr = '0;
    logic [31:0]  wr_data = '0;
    logic         start = 1'b0;
    logic         stop = 1'b0;
    logic         loop = 1'b0;
    logic [2:0]   nframes = '0;
    logic         m_axis_tready = 1'b0;
    logic [31:0]  m_axis_tdata;
    logic         m_axis_tvalid;
    logic         m_axis_tlast;
    logic [2:0]   m_axis_tuser;
    logic         busy;
    logic         done;
    logic         wr_err;

    axis_frame_player #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .FRAME_LEN (FRAME_LEN),
        .CNT_WID   (CNT_WID)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .start         (start),
        .stop          (stop),
        .loop          (loop),
        .nframes       (nframes),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tuser  (m_axis_tuser),
        .busy          (busy),
        .done          (done),
        .wr_err        (wr_err)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] model [DEPTH];
    logic [35:0] cap [$];
    int          done_cnt = 0;
    int          wr_err_cnt = 0;
    logic        rnd_ready = 1'b0;
    logic        fix_ready = 1'b1;
    logic        prev_stall = 1'b0;
    logic        prev_rst = 1'b1;
    logic [35:0] prev_bus = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected beat k of a run: samples in address order, frames of FRAME_LEN, frame index mod 2^CNT_WID.
    function automatic logic [35:0] exp_beat(input int k);
        int          a;
        logic        last;
        logic [2:0]  user;
        a    = k % DEPTH;
        last = ((a % FRAME_LEN) == FRAME_LEN - 1);
        user = 3'((k / FRAME_LEN) % 8);
        return {model[a], last, user};
    endfunction

    task automatic check_stream(input string tag, input int n);
        check({tag, "_beats"}, 64'(cap.size()), 64'(n));
        for (int k = 0; k < n && k < cap.size(); k++) begin
            check({tag, "_beat"}, 64'(cap[k]), 64'(exp_beat(k)));
        end
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n;
        n = 0;
        while (done !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        check({tag, "_done_seen"}, 64'(done), 64'(1));
    endtask

    task automatic wait_beats(input string tag, input int nb, input int budget);
        int n;
        n = 0;
        while (cap.size() < nb && n < budget) begin
            tick();
            n++;
        end
        check({tag, "_beats_reached"}, 64'(cap.size() >= nb), 64'(1));
    endtask

    task automatic run(input logic [2:0] nf, input logic lp);
        cap.delete();
        done_cnt = 0;
        nframes  = nf;
        loop     = lp;
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    task automatic write_word(input int a, input logic [31:0] d);
        wr_en   = 1'b1;
        wr_addr = 6'(a);
        wr_data = d;
        model[a] = d;
        tick();
        wr_en   = 1'b0;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #2;
            m_axis_tready = rnd_ready ? 1'($urandom_range(0, 1)) : fix_ready;
        end
    end

    // Monitor: records handshakes and checks that a stalled beat holds until accepted.
    always @(negedge clk) begin
        logic [35:0] bus;
        bus = {m_axis_tdata, m_axis_tlast, m_axis_tuser};
        if (prev_stall && !prev_rst) begin
            check("hold_tvalid", 64'(m_axis_tvalid), 64'(1));
            check("hold_bus", 64'(bus), 64'(prev_bus));
        end
        if (m_axis_tvalid && m_axis_tready && !rst) begin
            cap.push_back(bus);
        end
        if (done) done_cnt++;
        if (wr_err) wr_err_cnt++;
        prev_stall = m_axis_tvalid && !m_axis_tready;
        prev_bus   = bus;
        prev_rst   = rst;
    end

    initial begin
        cx_t c;

        rst = 1'b1;
        repeat (3) tick();
        check("rst_tvalid", 64'(m_axis_tvalid), 64'(0));
        check("rst_tlast", 64'(m_axis_tlast), 64'(0));
        check("rst_tuser", 64'(m_axis_tuser), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_wr_err", 64'(wr_err), 64'(0));
        rst = 1'b0;
        tick();

        for (int i = 0; i < DEPTH; i++) begin
            c.im = 16'(i);
            c.re = 16'(-i);
            write_word(i, c);
        end

        // Four frames at full rate, latency of two cycles from start.
        fix_ready = 1'b1;
        rnd_ready = 1'b0;
        tick();
        run(3'd4, 1'b0);
        check("t1_gap_tvalid", 64'(m_axis_tvalid), 64'(0));
        check("t1_busy", 64'(busy), 64'(1));
        tick();
        check("t1_first_tvalid", 64'(m_axis_tvalid), 64'(1));
        wait_done("t1", 500);
        repeat (3) tick();
        check_stream("t1", 64);
        check("t1_done_cnt", 64'(done_cnt), 64'(1));
        check("t1_busy_end", 64'(busy), 64'(0));

        // Same playback under random backpressure.
        rnd_ready = 1'b1;
        run(3'd4, 1'b0);
        wait_done("t2", 2000);
        repeat (3) tick();
        check_stream("t2", 64);
        check("t2_done_cnt", 64'(done_cnt), 64'(1));

        // Looping, stop mid-frame 5: stream ends at the end of frame 5.
        run(3'd0, 1'b1);
        wait_beats("t3", 5 * FRAME_LEN + 7, 3000);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        wait_done("t3", 2000);
        repeat (3) tick();
        check_stream("t3", 96);
        rnd_ready = 1'b0;

        // Looping past the tuser wrap, stop mid-frame 10.
        run(3'd0, 1'b1);
        wait_beats("t3b", 10 * FRAME_LEN + 5, 3000);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        wait_done("t3b", 500);
        repeat (3) tick();
        check_stream("t3b", 176);

        // Write during playback is dropped and flagged.
        run(3'd4, 1'b0);
        repeat (5) tick();
        wr_err_cnt = 0;
        wr_en   = 1'b1;
        wr_addr = 6'd3;
        wr_data = 32'hdead_beef;
        tick();
        wr_en   = 1'b0;
        check("t4_wr_err", 64'(wr_err), 64'(1));
        tick();
        check("t4_wr_err_pulse", 64'(wr_err), 64'(0));
        wait_done("t4", 500);
        repeat (3) tick();
        check_stream("t4_first", 64);
        check("t4_wr_err_cnt", 64'(wr_err_cnt), 64'(1));
        run(3'd4, 1'b0);
        wait_done("t4r", 500);
        repeat (3) tick();
        check_stream("t4_replay", 64);

        // Random idle writes, then a write to address 0 in the start cycle.
        for (int j = 0; j < 8; j++) begin
            write_word(int'($urandom_range(1, DEPTH - 1)), $urandom);
        end
        wr_en    = 1'b1;
        wr_addr  = 6'd0;
        wr_data  = $urandom;
        model[0] = wr_data;
        run(3'd4, 1'b0);
        wr_en    = 1'b0;
        wait_done("t5", 500);
        repeat (3) tick();
        check_stream("t5", 64);

        // nframes=0 without loop: immediate done, no stream, never busy.
        run(3'd0, 1'b0);
        check("t6_done", 64'(done), 64'(1));
        check("t6_busy", 64'(busy), 64'(0));
        check("t6_tvalid", 64'(m_axis_tvalid), 64'(0));
        tick();
        check("t6_done_pulse", 64'(done), 64'(0));
        check("t6_busy2", 64'(busy), 64'(0));
        repeat (3) tick();
        check("t6_no_beats", 64'(cap.size()), 64'(0));
        check("t6_done_cnt", 64'(done_cnt), 64'(1));

        // Reset mid-frame while stalled, then a clean replay.
        fix_ready = 1'b1;
        run(3'd4, 1'b0);
        wait_beats("t7", 20, 500);
        fix_ready = 1'b0;
        repeat (3) tick();
        check("t7_stalled_tvalid", 64'(m_axis_tvalid), 64'(1));
        rst = 1'b1;
        tick();
        check("t7_rst_tvalid", 64'(m_axis_tvalid), 64'(0));
        check("t7_rst_busy", 64'(busy), 64'(0));
        rst = 1'b0;
        fix_ready = 1'b1;
        tick();
        run(3'd2, 1'b0);
        wait_done("t7r", 500);
        repeat (3) tick();
        check_stream("t7_replay", 32);

        // Second start while busy is ignored.
        run(3'd2, 1'b0);
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done("t8", 500);
        repeat (5) tick();
        check_stream("t8", 32);
        check("t8_done_cnt", 64'(done_cnt), 64'(1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
